// File: rtl/psdsqrt.sv
//==============================================================================
// Module      : psdsqrt
// Description : Sequential unsigned integer square root. Computes
//               round(sqrt(xin)) using DECIMAL guard fractional bits and
//               round-half-to-even on those bits. One root bit per clock
//               (restoring digit-by-digit). A start pulse launches the
//               computation and a stop pulse loads the rounded result into
//               the sqrt output register.
//               Optional macro PSDSQRT_SAT_EN: saturate the result to all
//               ones when rounding overflows NBITS/2 bits (otherwise wraps).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module psdsqrt #(
    parameter int NBITS   = 32,
    parameter int DECIMAL = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic [NBITS-1:0]   xin,
    output logic [NBITS/2-1:0] sqrt
);

    localparam int NBITS_INT = NBITS + 2 * DECIMAL;
    localparam int ITER      = NBITS_INT / 2;
    localparam int HALF      = NBITS / 2;
    localparam int CW        = $clog2(ITER + 1);
    localparam int RW        = ITER + 2;

    // Working registers
    logic [NBITS_INT-1:0] radicand;
    logic [RW-1:0]        rem;
    logic [ITER-1:0]      root;
    logic [CW-1:0]        count;
    logic                 busy;

    // Iteration datapath
    logic [RW-1:0]        rem_shift;
    logic [RW-1:0]        trial;
    logic [RW-1:0]        rem_next;
    logic [ITER-1:0]      root_next;

    // Rounding datapath
    logic [DECIMAL-1:0]   frac;
    logic [DECIMAL-1:0]   half_lsb;
    logic [HALF-1:0]      quot;
    logic                 round_up;
    logic [HALF-1:0]      rounded;

    // One restoring step: bring in the next radicand bit pair and try to
    // subtract (4*root + 1). The remainder never exceeds 2*root, so dropping
    // its top two bits on the shift loses nothing.
    always_comb begin
        rem_shift = {rem[RW-3:0], radicand[NBITS_INT-1 -: 2]};
        trial     = {root, 2'b01};
        rem_next  = rem_shift;
        root_next = {root[ITER-2:0], 1'b0};
        if (rem_shift >= trial) begin
            rem_next  = rem_shift - trial;
            root_next = {root[ITER-2:0], 1'b1};
        end
    end

    // Round-half-to-even on the DECIMAL guard bits of the current root
    always_comb begin
        frac     = root[DECIMAL-1:0];
        half_lsb = DECIMAL'(1) << (DECIMAL - 1);
        quot     = root[ITER-1:DECIMAL];
        round_up = (frac > half_lsb) || ((frac == half_lsb) && root[DECIMAL]);
`ifdef PSDSQRT_SAT_EN
        // Overflow only occurs when quot is all ones and rounds up
        if (round_up && (&quot)) begin
            rounded = {HALF{1'b1}};
        end else begin
            rounded = quot + HALF'(round_up);
        end
`else
        rounded  = quot + HALF'(round_up);
`endif
    end

    // Computation control: start (re)loads the radicand, busy iterates
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            radicand <= '0;
            rem      <= '0;
            root     <= '0;
            count    <= '0;
            busy     <= 1'b0;
        end else if (start) begin
            radicand <= {xin, {(2 * DECIMAL){1'b0}}};
            rem      <= '0;
            root     <= '0;
            count    <= '0;
            busy     <= 1'b1;
        end else if (busy) begin
            radicand <= {radicand[NBITS_INT-3:0], 2'b00};
            rem      <= rem_next;
            root     <= root_next;
            count    <= count + CW'(1);
            if (count == CW'(ITER - 1)) begin
                busy <= 1'b0;
            end
        end
    end

    // Output register: loaded from the current (pre-start) root on stop
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sqrt <= '0;
        end else if (stop) begin
            sqrt <= rounded;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_psdsqrt.sv
//==============================================================================
// Module      : tb_psdsqrt
// Description : Self-checking bench for psdsqrt. Expected roots come from a
//               binary-search integer square root plus round-half-to-even,
//               queued at start and compared after stop.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_psdsqrt;

    localparam int NBITS   = 32;
    localparam int DECIMAL = 4;
    localparam int ITER    = (NBITS + 2 * DECIMAL) / 2;

    logic              clock;
    logic              reset;
    logic              start;
    logic              stop;
    logic [NBITS-1:0]  xin;
    logic [15:0]       sqrt;

    int                n_checks;
    int                n_fail;
    logic [15:0]       sb[$];

    psdsqrt #(.NBITS(NBITS), .DECIMAL(DECIMAL)) dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .stop  (stop),
        .xin   (xin),
        .sqrt  (sqrt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: floor sqrt by binary search, then round half to even
    function automatic logic [15:0] model(input logic [31:0] x);
        longint big, lo, hi, mid, r, f, q;
        big = longint'(x) << (2 * DECIMAL);
        lo  = 0;
        hi  = longint'(1) << ITER;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (mid * mid <= big) lo = mid;
            else hi = mid;
        end
        r = lo;
        f = r % (1 << DECIMAL);
        q = r >> DECIMAL;
        if (f > (1 << (DECIMAL - 1))) q = q + 1;
        else if (f == (1 << (DECIMAL - 1)) && (q % 2 == 1)) q = q + 1;
`ifdef PSDSQRT_SAT_EN
        if (q > 65535) q = 65535;
`endif
        return 16'(q);
    endfunction

    task automatic pulse_start(input logic [31:0] x);
        @(negedge clock);
        xin   = x;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        sb.push_back(model(x));
    endtask

    task automatic pulse_stop_and_check(input string tag);
        logic [15:0] exp;
        @(negedge clock);
        stop = 1'b1;
        @(posedge clock);
        #1;
        check({tag, "_sb_depth"}, sb.size() != 0, 1);
        exp = (sb.size() != 0) ? sb.pop_front() : 16'hxxxx;
        check(tag, sqrt, exp);
        @(negedge clock);
        stop = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [31:0] x);
        pulse_start(x);
        repeat (ITER) @(negedge clock);
        pulse_stop_and_check(tag);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        start    = 1'b0;
        stop     = 1'b0;
        xin      = '0;
        repeat (3) @(negedge clock);
        #1;
        check("reset_sqrt", sqrt, 0);
        @(negedge clock);
        reset = 1'b0;

        run_op("x0", 0);
        check("x0_const", sqrt, 0);
        run_op("x1", 1);
        check("x1_const", sqrt, 1);
        run_op("x2", 2);
        check("x2_const", sqrt, 1);
        run_op("x12", 12);
        check("x12_const", sqrt, 3);
        run_op("x13", 13);
        check("x13_const", sqrt, 4);
        run_op("tie_even", 1057);
        check("tie_even_const", sqrt, 32);
        run_op("tie_odd", 4291);
        check("tie_odd_const", sqrt, 66);

        for (int i = 0; i < 32; i++) begin
            run_op($sformatf("pow2_%0d", i), 32'd1 << i);
            run_op($sformatf("pow2p_%0d", i), (32'd1 << i) + 32'(i));
        end
        run_op("x2p31_const_prep", 32'h8000_0000);
        check("x2p31_const", sqrt, 46341);

        run_op("xmax", 32'hFFFF_FFFF);
`ifdef PSDSQRT_SAT_EN
        check("xmax_const", sqrt, 16'hFFFF);
`else
        check("xmax_const", sqrt, 0);
`endif

        // Asynchronous reset mid-iteration; sqrt is nonzero beforehand
        run_op("pre_reset", 1000);
        @(negedge clock);
        xin   = 13;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (5) @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset", sqrt, 0);
        @(negedge clock);
        reset = 1'b0;
        run_op("after_reset", 13);
        check("after_reset_const", sqrt, 4);

        // Start without stop must not disturb sqrt
        pulse_start(1057);
        repeat (ITER + 3) @(negedge clock);
        check("hold_no_stop", sqrt, 4);
        pulse_stop_and_check("held_then_stop");
        check("held_then_stop_const", sqrt, 32);

        // Simultaneous start and stop: sqrt takes the old root (32)
        @(negedge clock);
        xin   = 13;
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clock);
        start = 1'b0;
        stop  = 1'b0;
        check("start_stop_old", sqrt, 32);
        sb.push_back(model(13));
        repeat (ITER) @(negedge clock);
        pulse_stop_and_check("start_stop_new");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
